ctrl_pipe: RTL and testbench

Back-end consumer of the decode-stage control bundles (wb[1:0], mem[2:0], ex[3:0]) in the 5-stage MIPS pipeline. It unpacks the ID/EX-registered bundle into EX-stage control signals and carries the mem/wb fields through the EX/MEM and MEM/WB control registers. It also detects load-use hazards, resolves branches in MEM, inserts bubbles by masking bundles, and keeps saturating stall/flush counters.

---
 rtl/ctrl_pkg.sv | 29 ++
 rtl/ctrl_pipe_hazard.sv | 13 +
 rtl/ctrl_pipe.sv | 82 ++++++++
 tb/tb_ctrl_pipe.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, control-bundle field layout and widths shared by the pipeline control path
package ctrl_pkg;
    localparam int WB_W  = 2;
    localparam int MEM_W = 3;
    localparam int EX_W  = 4;
    localparam int REG_W = 5;
    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;
    localparam int MEM_BRANCH   = 2;
    localparam int MEM_READ     = 1;
    localparam int MEM_WRITE    = 0;
    localparam int EX_REGDST    = 3;
    localparam int EX_ALUOP_HI  = 2;
    localparam int EX_ALUOP_LO  = 1;
    localparam int EX_ALUSRC    = 0;
    typedef enum logic [2:0] {NOP, RTYPE, LW, SW, BEQ} opcode_e;
    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  ex;
    } bundle_t;
    // Decode-stage encoding of each opcode into its {wb, mem, ex} bundle
    function automatic bundle_t encode(opcode_e op);
        return op == RTYPE ? bundle_t'({2'b10, 3'b000, 4'b1100}) :
               op == LW    ? bundle_t'({2'b11, 3'b010, 4'b0001}) :
               op == SW    ? bundle_t'({2'b00, 3'b001, 4'b0001}) :
               op == BEQ   ? bundle_t'({2'b00, 3'b100, 4'b0010}) : bundle_t'('0);
    endfunction
endpackage

// File: rtl/ctrl_pipe_hazard.sv
// hazard_detect: combinational load-use comparator; a taken branch suppresses the stall
module hazard_detect
    import ctrl_pkg::*;
(
    input  logic             memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             pc_src,
    output logic             stall
);
    assign stall = memread & (ex_rt != '0) & (ex_rt == id_rs | ex_rt == id_rt) & ~pc_src;
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: EX/MEM/WB control pipeline with load-use stall, branch flush and saturating event counters
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WB_W-1:0]  ex_wb,
    input  logic [MEM_W-1:0] ex_mem,
    input  logic [EX_W-1:0]  ex_ex,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             mem_zero,
    output logic             ex_regdst,
    output logic             ex_alusrc,
    output logic [1:0]       ex_aluop,
    output logic             mem_branch,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             pc_src,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic             stall,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic             bubble_q;
    logic             kill_ex;
    logic [WB_W-1:0]  wb_m;
    logic [MEM_W-1:0] mem_m;
    logic [EX_W-1:0]  ex_m;
    logic [WB_W-1:0]  exmem_wb;
    logic [MEM_W-1:0] exmem_mem;
    logic [WB_W-1:0]  memwb_wb;

    assign pc_src     = exmem_mem[MEM_BRANCH] & mem_zero;
    assign ifid_flush = pc_src;
    // A squashed EX slot behaves exactly like a NOP everywhere downstream
    assign kill_ex = pc_src | bubble_q;
    assign wb_m    = kill_ex ? '0 : ex_wb;
    assign mem_m   = kill_ex ? '0 : ex_mem;
    assign ex_m    = kill_ex ? '0 : ex_ex;

    assign ex_regdst    = ex_m[EX_REGDST];
    assign ex_aluop     = ex_m[EX_ALUOP_HI:EX_ALUOP_LO];
    assign ex_alusrc    = ex_m[EX_ALUSRC];
    assign mem_branch   = exmem_mem[MEM_BRANCH];
    assign mem_memread  = exmem_mem[MEM_READ];
    assign mem_memwrite = exmem_mem[MEM_WRITE];
    assign wb_regwrite  = memwb_wb[WB_REGWRITE];
    assign wb_memtoreg  = memwb_wb[WB_MEMTOREG];

    hazard_detect u_hazard (
        .memread (mem_m[MEM_READ]),
        .ex_rt   (ex_rt),
        .id_rs   (id_rs),
        .id_rt   (id_rt),
        .pc_src  (pc_src),
        .stall   (stall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q  <= 1'b0;
            exmem_wb  <= '0;
            exmem_mem <= '0;
            memwb_wb  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            bubble_q  <= stall | pc_src;
            exmem_wb  <= wb_m;
            exmem_mem <= mem_m;
            memwb_wb  <= exmem_wb;
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if (pc_src && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed and random checks of ctrl_pipe against an in-flight-instruction reference model
module tb_ctrl_pipe;
    localparam int CNT_W = 10;
    localparam int SAT   = (1 << CNT_W) - 1;
    localparam int OP_NOP = 0, OP_RTYPE = 1, OP_LW = 2, OP_SW = 3, OP_BEQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] ex_wb = '0;
    logic [2:0] ex_mem = '0;
    logic [3:0] ex_ex = '0;
    logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;
    logic mem_zero = 1'b0;
    logic ex_regdst, ex_alusrc, mem_branch, mem_memread, mem_memwrite, pc_src;
    logic wb_regwrite, wb_memtoreg, stall, ifid_flush;
    logic [1:0] ex_aluop;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    ctrl_pipe #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .ex_wb(ex_wb), .ex_mem(ex_mem), .ex_ex(ex_ex),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .mem_zero(mem_zero),
        .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .mem_branch(mem_branch), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .pc_src(pc_src), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .stall(stall), .ifid_flush(ifid_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] mem;
        logic [3:0] ex;
    } bnd_t;

    int n_vec = 0;
    int n_bad = 0;
    // Surviving {mem, wb} of instructions past EX: [0] is in MEM, [1] is in WB
    logic [4:0] inflight[$];
    logic m_bub;
    int m_sc, m_fc;

    function automatic bnd_t bnd(int op);
        case (op)
            OP_RTYPE: return {2'b10, 3'b000, 4'b1100};
            OP_LW:    return {2'b11, 3'b010, 4'b0001};
            OP_SW:    return {2'b00, 3'b001, 4'b0001};
            OP_BEQ:   return {2'b00, 3'b100, 4'b0010};
            default:  return '0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inflight = {5'd0, 5'd0};
        m_bub = 1'b0;
        m_sc = 0;
        m_fc = 0;
    endtask

    task automatic step(input int op, input int rt, input int rs, input int irt, input logic z, input logic r = 1'b0);
        bnd_t b, v;
        logic [4:0] em, mw;
        logic pc, st;
        b = bnd(op);
        {ex_wb, ex_mem, ex_ex} = b;
        ex_rt = 5'(rt);
        id_rs = 5'(rs);
        id_rt = 5'(irt);
        mem_zero = z;
        rst = r;
        #4;
        em = inflight[0];
        mw = inflight[1];
        pc = em[4] & z;
        v = (pc | m_bub) ? '0 : b;
        st = v.mem[1] && rt != 0 && (rt == rs || rt == irt) && !pc;
        chk("ex_ctrl", {ex_regdst, ex_aluop, ex_alusrc}, v.ex);
        chk("mem_ctrl", {mem_branch, mem_memread, mem_memwrite}, em[4:2]);
        chk("wb_ctrl", {wb_regwrite, wb_memtoreg}, mw[1:0]);
        chk("pc_src_flush", {pc_src, ifid_flush}, {pc, pc});
        chk("stall", stall, st);
        chk("stall_cnt", stall_cnt, m_sc);
        chk("flush_cnt", flush_cnt, m_fc);
        @(posedge clk);
        if (r) model_reset();
        else begin
            inflight.push_front({v.mem, v.wb});
            void'(inflight.pop_back());
            m_bub = st | pc;
            if (st && m_sc < SAT) m_sc++;
            if (pc && m_fc < SAT) m_fc++;
        end
        #1;
    endtask

    int sc0;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_outs", {ex_regdst, ex_alusrc, ex_aluop, mem_branch, mem_memread, mem_memwrite,
                           pc_src, wb_regwrite, wb_memtoreg, stall, ifid_flush}, 0);
        chk("reset_cnts", {stall_cnt, flush_cnt}, 0);
        #3;
        // RTYPE flows EX -> MEM -> WB
        step(OP_RTYPE, 1, 2, 3, 1'b0);
        chk("rtype_mem", {mem_branch, mem_memread, mem_memwrite}, 3'b000);
        step(OP_NOP, 0, 0, 0, 1'b0);
        chk("rtype_wb", {wb_regwrite, wb_memtoreg}, 2'b10);
        step(OP_NOP, 0, 0, 0, 1'b0);
        // Load-use: one stall, then one squashed slot, then the dependent passes
        step(OP_LW, 5, 5, 0, 1'b0);
        chk("lu_cnt", stall_cnt, 1);
        chk("lu_bubble_ex", {ex_regdst, ex_aluop, ex_alusrc}, 4'b0000);
        chk("lu_bubble_stall", stall, 1'b0);
        step(OP_LW, 5, 5, 0, 1'b0);
        step(OP_RTYPE, 5, 7, 8, 1'b0);
        step(OP_LW, 0, 0, 0, 1'b0);
        chk("lu_rt0_cnt", stall_cnt, 1);
        step(OP_NOP, 0, 0, 0, 1'b0);
        // Taken branch: EX masked this cycle and the next
        step(OP_BEQ, 0, 0, 0, 1'b1);
        chk("beq_taken", {pc_src, ifid_flush}, 2'b11);
        step(OP_RTYPE, 0, 0, 0, 1'b1);
        chk("beq_bubble_ex", {ex_regdst, ex_aluop, ex_alusrc}, 4'b0000);
        step(OP_RTYPE, 0, 0, 0, 1'b0);
        chk("beq_exmem", {mem_branch, mem_memread, mem_memwrite}, 3'b000);
        chk("beq_flush_cnt", flush_cnt, 1);
        step(OP_NOP, 0, 0, 0, 1'b0);
        // Branch and load-use together: branch wins
        sc0 = m_sc;
        step(OP_BEQ, 0, 0, 0, 1'b1);
        chk("br_lu_pc", pc_src, 1'b1);
        chk("br_lu_stall", stall, 1'b0);
        step(OP_LW, 5, 5, 0, 1'b1);
        chk("br_lu_cnt", stall_cnt, sc0);
        // Random traffic with small register numbers to provoke hazards
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
        // Continuous load-use pressure until the stall counter saturates
        for (int i = 0; i < 2 * SAT + 40; i++) step(OP_LW, 5, 5, 5, 1'b0);
        chk("stall_sat", stall_cnt, SAT);
        step(OP_NOP, 0, 0, 0, 1'b0, 1'b1);
        chk("midrst_outs", {ex_regdst, ex_alusrc, ex_aluop, mem_branch, mem_memread, mem_memwrite,
                            pc_src, wb_regwrite, wb_memtoreg, stall, ifid_flush}, 0);
        chk("midrst_cnts", {stall_cnt, flush_cnt}, 0);
        step(OP_NOP, 0, 0, 0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
